// File: rtl/attn_pkg.sv
// Shared defaults, FSM state type and width helpers for the binary attention core.
package attn_pkg;

    localparam int unsigned SEQ_LEN_DEF = 30;
    localparam int unsigned D_MODEL_DEF = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StAcc  = 2'd2,
        StOut  = 2'd3
    } attn_state_e;

    // Signed score spans -D_MODEL..+D_MODEL.
    function automatic int unsigned score_w(int unsigned d_model);
        return $clog2(d_model + 1) + 1;
    endfunction

    function automatic int unsigned acc_w(int unsigned d_model, int unsigned seq_len);
        return score_w(d_model) + $clog2(seq_len);
    endfunction

endpackage

// File: rtl/binary_attn_core_if.sv
// Token-in / vector-out handshake bundle for binary_attn_core.
interface binary_attn_core_if
    import attn_pkg::*;
#(
    parameter int unsigned D_MODEL = D_MODEL_DEF,
    parameter int unsigned LEN_W   = $clog2(SEQ_LEN_DEF + 1)
);
    logic               in_valid;
    logic               in_ready;
    logic [D_MODEL-1:0] q_in;
    logic [D_MODEL-1:0] k_in;
    logic [D_MODEL-1:0] v_in;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_causal;
    logic               out_valid;
    logic               out_ready;
    logic [D_MODEL-1:0] out_data;
    logic [LEN_W-1:0]   out_idx;
    logic               out_last;
    logic               busy;

    modport master (
        output in_valid, q_in, k_in, v_in, cfg_len, cfg_causal, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, q_in, k_in, v_in, cfg_len, cfg_causal, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy
    );
endinterface

// File: rtl/xnor_popcount_score.sv
// Combinational binary dot product: D_MODEL - 2*popcount(a ^ b) as a signed score.
module xnor_popcount_score #(
    parameter int unsigned D_MODEL = 16,
    parameter int unsigned SW      = 6
) (
    input  logic [D_MODEL-1:0]    i_a,
    input  logic [D_MODEL-1:0]    i_b,
    output logic signed [SW-1:0]  o_s
);
    logic [D_MODEL-1:0] w_diff;
    logic [SW-1:0]      w_cnt;

    assign w_diff = i_a ^ i_b;

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < D_MODEL; i++) begin
            w_cnt = w_cnt + SW'(w_diff[i]);
        end
    end

    // Modular subtraction wraps into the correct two's-complement score.
    assign o_s = $signed(SW'(D_MODEL) - {w_cnt[SW-2:0], 1'b0});
endmodule

// File: rtl/binary_attn_core.sv
// Binary self-attention core: buffers q/k/v tokens, accumulates one key per cycle per query,
// emits one sign-binarised vector per query.
module binary_attn_core
    import attn_pkg::*;
#(
    parameter int unsigned SEQ_LEN = SEQ_LEN_DEF,
    parameter int unsigned D_MODEL = D_MODEL_DEF,
    parameter int unsigned LEN_W   = $clog2(SEQ_LEN + 1)
) (
    input logic               clk,
    input logic               rst_n,
    binary_attn_core_if.slave bus
);
    localparam int unsigned SW    = score_w(D_MODEL);
    localparam int unsigned AW    = acc_w(D_MODEL, SEQ_LEN);
    localparam int unsigned IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(SEQ_LEN);

    attn_state_e         r_state;
    logic [LEN_W-1:0]    r_len;
    logic                r_causal;
    logic [LEN_W-1:0]    r_wr_ptr;
    logic [LEN_W-1:0]    r_q_idx;
    logic [LEN_W-1:0]    r_k_idx;
    logic [D_MODEL-1:0]  r_out_data;
    logic signed [AW-1:0] r_acc [D_MODEL];

    logic [D_MODEL-1:0]  r_q [SEQ_LEN];
    logic [D_MODEL-1:0]  r_k [SEQ_LEN];
    logic [D_MODEL-1:0]  r_v [SEQ_LEN];

    logic                 w_in_hs;
    logic [LEN_W-1:0]     w_len_lat;
    logic [LEN_W-1:0]     w_len_m1;
    logic [LEN_W-1:0]     w_k_last;
    logic [IDX_W-1:0]     w_wr_idx;
    logic [D_MODEL-1:0]   w_v_row;
    logic signed [SW-1:0] w_score;
    logic signed [AW-1:0] w_score_ext;
    logic signed [AW-1:0] w_acc_next [D_MODEL];
    logic [D_MODEL-1:0]   w_sign;
    logic                 w_out_last;

    assign w_in_hs   = bus.in_valid && bus.in_ready;
    assign w_len_lat = (bus.cfg_len == '0 || bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;
    assign w_len_m1  = r_len - LEN_W'(1);
    assign w_k_last  = r_causal ? r_q_idx : w_len_m1;
    assign w_wr_idx  = (r_state == StIdle) ? '0 : r_wr_ptr[IDX_W-1:0];
    assign w_v_row   = r_v[r_k_idx[IDX_W-1:0]];

    xnor_popcount_score #(
        .D_MODEL(D_MODEL),
        .SW     (SW)
    ) u_score (
        .i_a(r_q[r_q_idx[IDX_W-1:0]]),
        .i_b(r_k[r_k_idx[IDX_W-1:0]]),
        .o_s(w_score)
    );

    assign w_score_ext = AW'(w_score);

    always_comb begin
        for (int d = 0; d < D_MODEL; d++) begin
            w_acc_next[d] = w_v_row[d] ? r_acc[d] + w_score_ext : r_acc[d] - w_score_ext;
            w_sign[d]     = ~w_acc_next[d][AW-1];
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_q[w_wr_idx] <= bus.q_in;
            r_k[w_wr_idx] <= bus.k_in;
            r_v[w_wr_idx] <= bus.v_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_len      <= '0;
            r_causal   <= 1'b0;
            r_wr_ptr   <= '0;
            r_q_idx    <= '0;
            r_k_idx    <= '0;
            r_out_data <= '0;
            for (int d = 0; d < D_MODEL; d++) r_acc[d] <= '0;
        end else begin
            unique case (r_state)
                StIdle: if (w_in_hs) begin
                    r_len    <= w_len_lat;
                    r_causal <= bus.cfg_causal;
                    r_wr_ptr <= LEN_W'(1);
                    r_q_idx  <= '0;
                    r_k_idx  <= '0;
                    for (int d = 0; d < D_MODEL; d++) r_acc[d] <= '0;
                    r_state  <= (w_len_lat == LEN_W'(1)) ? StAcc : StLoad;
                end
                StLoad: if (w_in_hs) begin
                    r_wr_ptr <= r_wr_ptr + LEN_W'(1);
                    if (r_wr_ptr == w_len_m1) r_state <= StAcc;
                end
                StAcc: begin
                    for (int d = 0; d < D_MODEL; d++) r_acc[d] <= w_acc_next[d];
                    if (r_k_idx == w_k_last) begin
                        r_out_data <= w_sign;
                        r_state    <= StOut;
                    end else begin
                        r_k_idx <= r_k_idx + LEN_W'(1);
                    end
                end
                StOut: if (bus.out_ready) begin
                    if (w_out_last) begin
                        r_state <= StIdle;
                    end else begin
                        r_q_idx <= r_q_idx + LEN_W'(1);
                        r_k_idx <= '0;
                        for (int d = 0; d < D_MODEL; d++) r_acc[d] <= '0;
                        r_state <= StAcc;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_out_last    = (r_state == StOut) && (r_q_idx == w_len_m1);
    assign bus.in_ready  = (r_state == StIdle) || (r_state == StLoad);
    assign bus.out_valid = (r_state == StOut);
    assign bus.out_data  = r_out_data;
    assign bus.out_idx   = r_q_idx;
    assign bus.out_last  = w_out_last;
    assign bus.busy      = (r_state != StIdle);
endmodule

// File: tb/tb_binary_attn_core.sv
// Directed self-checking bench for binary_attn_core (SEQ_LEN=30, D_MODEL=16).
module tb_binary_attn_core;
    localparam int unsigned SEQ_LEN = 30;
    localparam int unsigned D_MODEL = 16;
    localparam int unsigned LEN_W   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    binary_attn_core_if #(.D_MODEL(D_MODEL), .LEN_W(LEN_W)) bus ();

    binary_attn_core #(
        .SEQ_LEN(SEQ_LEN),
        .D_MODEL(D_MODEL),
        .LEN_W  (LEN_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] q, input logic [15:0] k, input logic [15:0] v,
                        input int len, input bit causal);
        bit acc = 1'b0;
        int n = 0;
        bus.in_valid   = 1'b1;
        bus.q_in       = q;
        bus.k_in       = k;
        bus.v_in       = v;
        bus.cfg_len    = LEN_W'(len);
        bus.cfg_causal = causal;
        while (!acc && n < 200) begin
            acc = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) check_eq("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic recv(input string tag, input logic [15:0] ed, input int ei, input bit el,
                        input int elat, input int hold);
        int lat;
        wait_out(lat);
        if (elat >= 0) check_eq({tag, "_lat"}, lat, elat);
        check_eq({tag, "_data"}, bus.out_data, ed);
        check_eq({tag, "_idx"}, bus.out_idx, ei);
        check_eq({tag, "_last"}, bus.out_last, el);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_eq({tag, "_hold_valid"}, bus.out_valid, 1);
            check_eq({tag, "_hold_data"}, bus.out_data, ed);
            check_eq({tag, "_hold_idx"}, bus.out_idx, ei);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, bus.in_ready, 1);
        check_eq({tag, "_out_valid"}, bus.out_valid, 0);
        check_eq({tag, "_out_data"}, bus.out_data, 0);
        check_eq({tag, "_out_idx"}, bus.out_idx, 0);
        check_eq({tag, "_out_last"}, bus.out_last, 0);
        check_eq({tag, "_busy"}, bus.busy, 0);
    endtask

    task automatic run_neg_keys(input string tag);
        for (int i = 0; i < 3; i++) send(16'hFFFF, 16'h0000, 16'hFFFF, 3, 1'b0);
        for (int i = 0; i < 3; i++) recv(tag, 16'h0000, i, i == 2, 3, 0);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.q_in       = '0;
        bus.k_in       = '0;
        bus.v_in       = '0;
        bus.cfg_len    = '0;
        bus.cfg_causal = 1'b0;
        bus.out_ready  = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // All-ones: s=16 per key, acc=48 everywhere.
        send(16'hFFFF, 16'hFFFF, 16'hFFFF, 3, 1'b0);
        check_eq("ones_busy", bus.busy, 1);
        for (int i = 1; i < 3; i++) send(16'hFFFF, 16'hFFFF, 16'hFFFF, 3, 1'b0);
        for (int i = 0; i < 3; i++) recv("ones", 16'hFFFF, i, i == 2, 3, 0);
        check_eq("ones_idle", bus.busy, 0);

        run_neg_keys("negk");

        // Tie cases: +16 +16 -> FFFF; +16 -16 -> tie -> FFFF; mixed -> 0F0F.
        send(16'hFFFF, 16'hFFFF, 16'hFFFF, 2, 1'b0);
        send(16'hFFFF, 16'h0000, 16'h0000, 2, 1'b0);
        for (int i = 0; i < 2; i++) recv("tie_a", 16'hFFFF, i, i == 1, 2, 0);
        send(16'hFFFF, 16'hFFFF, 16'hFFFF, 2, 1'b0);
        send(16'hFFFF, 16'h0000, 16'hFFFF, 2, 1'b0);
        for (int i = 0; i < 2; i++) recv("tie_b", 16'hFFFF, i, i == 1, 2, 0);
        send(16'hFFFF, 16'hFFFF, 16'h0F0F, 2, 1'b0);
        send(16'hFFFF, 16'h0000, 16'hFFFF, 2, 1'b0);
        for (int i = 0; i < 2; i++) recv("mixed", 16'h0F0F, i, i == 1, 2, 0);

        // Causal: q0 sees only key0; q2 held under backpressure for 5 cycles.
        send(16'hFFFF, 16'hFFFF, 16'h00FF, 3, 1'b1);
        send(16'hFFFF, 16'hFFFF, 16'hFF00, 3, 1'b1);
        send(16'hFFFF, 16'hFFFF, 16'hFF00, 3, 1'b1);
        recv("causal0", 16'h00FF, 0, 1'b0, 1, 0);
        recv("causal1", 16'hFFFF, 1, 1'b0, 2, 0);
        recv("causal2", 16'hFF00, 2, 1'b1, 3, 5);

        // Asynchronous reset in the middle of ACC.
        for (int i = 0; i < 3; i++) send(16'hFFFF, 16'hFFFF, 16'hFFFF, 3, 1'b0);
        check_eq("pre_rst_busy", bus.busy, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midacc_rst");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_neg_keys("post_rst");

        // cfg_len=0 latches SEQ_LEN; input ignored while in_ready=0.
        for (int i = 0; i < SEQ_LEN; i++) send(16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 1'b0);
        check_eq("len0_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.q_in     = 16'h0000;
        bus.k_in     = 16'h1234;
        bus.v_in     = 16'h0000;
        repeat (4) begin
            @(posedge clk); #1;
            check_eq("len0_ignore_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < SEQ_LEN; i++)
            recv("len0", 16'hFFFF, i, i == SEQ_LEN - 1, (i == 0) ? -1 : SEQ_LEN, 0);
        check_eq("len0_done_busy", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/binary_attn_core.md
# binary_attn_core

Parametrised binary self-attention core, the next generation of the fixed 30×16 attention path. It buffers a sequence of binary query/key/value tokens. For every query it accumulates XNOR-popcount scores against the keys, weighted by each value's sign. It emits one sign-binarised output vector per query. Compared with the fixed block it adds:
- parameterised sequence depth and model width;
- runtime sequence length;
- an optional causal mask;
- valid/ready handshakes on both sides.

## Interface
Parameters:
- SEQ_LEN, 30, maximum tokens buffered
- D_MODEL, 16, bits per binary token (bit=1 means +1, bit=0 means −1)
- LEN_W, $clog2(SEQ_LEN+1), width of the length/index fields

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  token valid
- in_ready  out  1  core accepts a token
- q_in / k_in / v_in  in  D_MODEL each  binary query/key/value token
- cfg_len  in  LEN_W  sequence length; sampled with the first token
- cfg_causal  in  1  causal-mask enable; sampled with the first token
- out_valid  out  1  output vector valid
- out_ready  in  1  downstream accepts
- out_data  out  D_MODEL  binarised weighted value
- out_idx  out  LEN_W  query index of out_data
- out_last  out  1  out_idx == len−1
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, LOAD, ACC, OUT.
- IDLE:
  - in_ready=1.
  - On handshake, latch len and causal, write token 0, set wr_ptr=1.
  - Next state is LOAD, or ACC if len==1.
- Length latch: len = cfg_len, except cfg_len==0 or cfg_len>SEQ_LEN latches SEQ_LEN.
- LOAD:
  - in_ready=1.
  - Each handshake writes q/k/v[wr_ptr] and increments wr_ptr.
  - The handshake writing index len−1 moves to ACC with q_idx=0, k_idx=0, acc cleared.
- ACC:
  - in_ready=0. Each cycle processes one key.
  - s = D_MODEL − 2·popcount(q[q_idx] XOR k[k_idx]). Signed, range −D_MODEL..+D_MODEL.
  - For each d: acc[d] += v[k_idx][d] ? s : −s.
  - Last key: k_last = causal ? q_idx : len−1.
  - When k_idx==k_last, the update is applied, out_data[d] = (acc_next[d] >= 0), and the state moves to OUT.
  - Otherwise k_idx increments.
- OUT:
  - out_valid=1. out_data, out_idx=q_idx and out_last are held stable until out_ready.
  - On handshake with out_last=1, go to IDLE.
  - On handshake otherwise: q_idx++, k_idx=0, acc cleared, go to ACC.
- Ties: acc==0 outputs bit 1.
- Width rules:
  - Score width is SW = $clog2(D_MODEL+1)+1 signed.
  - Accumulator width is SW+$clog2(SEQ_LEN) signed; it cannot overflow.
- in_valid while in_ready=0 is ignored; the token is not consumed.
- Buffer contents persist after IDLE but are unused; every run reloads them.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0. State is IDLE, and all pointers and accumulators are 0.
- Reset is asynchronous at any point, including mid-LOAD or mid-ACC. It returns to IDLE; partial results are discarded with no output.
- Last token accepted at edge T → ACC starts at T+1.
  - Non-causal: out_valid rises at edge T+len.
  - Causal: query i's out_valid rises i+1 cycles after entering ACC.
- After the out handshake at edge U, the next query starts ACC at U+1.
- Throughput is one key per cycle. There is no internal pipelining; score, accumulation and sign are a single-cycle path from the register-array read.
- out_ready held low keeps OUT indefinitely with stable outputs.

## Structure
- Package attn_pkg:
  - default SEQ_LEN / D_MODEL localparams;
  - state enum (IDLE, LOAD, ACC, OUT);
  - score/accumulator width functions.
- Sub-module xnor_popcount_score (params D_MODEL, SW): purely combinational, a,b → signed s.
- Core holds:
  - q/k/v register arrays [SEQ_LEN][D_MODEL];
  - D_MODEL accumulators;
  - FSM and pointers.

## Test plan
- D_MODEL=16, len=3, all q=k=v=16'hFFFF → s=16 each, acc=48. Three outputs 16'hFFFF with out_idx 0,1,2; out_last only on idx 2. First out_valid 3 cycles after the last token.
- Same run with k=16'h0000 (s=−16) and v=16'hFFFF → all outputs 16'h0000.
- Tie: len=2, q=16'hFFFF, k0=16'hFFFF, k1=16'h0000, v0=16'hFFFF, v1=16'h0000 → acc=16+16=32 → 16'hFFFF. With v1=16'hFFFF instead, acc=0 → tie → 16'hFFFF.
- Causal: len=3, cfg_causal=1, q0=k0=16'hFFFF, v0=16'h00FF, keys 1–2 with v=16'hFF00 → query0 outputs 16'h00FF after 1 ACC cycle, unaffected by keys 1–2.
- Length and backpressure:
  - cfg_len=0 → exactly SEQ_LEN tokens are accepted.
  - out_ready low for 5 cycles → out_data/out_idx stable and no ACC progress.
- Reset asserted mid-ACC → all outputs go to reset values immediately. A new run then completes correctly.
